// File: rtl/fixed_addsub_cmp.sv
// Registered signed fixed-point adder/subtractor with signed magnitude compare.
// Optional feature: define FIXED_ADDSUB_SATURATE_EN to clamp result on overflow
// instead of wrapping; the overflow flag is raised in both builds.
module fixed_addsub_cmp #(
    parameter int unsigned INTEGER_WIDTH = 2,
    parameter int unsigned DECIMAL_WIDTH = 20,
    parameter int unsigned DATA_WIDTH    = INTEGER_WIDTH + DECIMAL_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clk_en,
    input  logic                  add_sub,
    input  logic [DATA_WIDTH-1:0] dataa,
    input  logic [DATA_WIDTH-1:0] datab,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  overflow,
    output logic                  aeb,
    output logic                  agb
);

    localparam int unsigned FULL_WIDTH = DATA_WIDTH + 1;
    localparam logic [DATA_WIDTH-1:0] MAX_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic [FULL_WIDTH-1:0] a_ext_c;
    logic [FULL_WIDTH-1:0] b_ext_c;
    logic [FULL_WIDTH-1:0] sum_c;
    logic                  ovf_c;
    logic [DATA_WIDTH-1:0] res_c;
    logic                  aeb_c;
    logic                  agb_c;

    // Full-precision sum/difference one bit wider than the operands, so the
    // true sign is always available in the top bit.
    always_comb begin
        a_ext_c = {dataa[DATA_WIDTH-1], dataa};
        b_ext_c = {datab[DATA_WIDTH-1], datab};
        if (add_sub) begin
            sum_c = a_ext_c + b_ext_c;
        end else begin
            sum_c = a_ext_c - b_ext_c;
        end
    end

    // Overflow when the two top bits of the wide result disagree; pick the
    // wrapped or clamped narrow result.
    always_comb begin
        ovf_c = sum_c[FULL_WIDTH-1] ^ sum_c[DATA_WIDTH-1];
        res_c = sum_c[DATA_WIDTH-1:0];
`ifdef FIXED_ADDSUB_SATURATE_EN
        if (ovf_c) begin
            res_c = sum_c[FULL_WIDTH-1] ? MIN_NEG : MAX_POS;
        end
`else
        if (ovf_c && (res_c == MAX_POS || res_c == MIN_NEG)) begin
            res_c = sum_c[DATA_WIDTH-1:0];
        end
`endif
    end

    // Signed comparison, independent of add_sub.
    always_comb begin
        aeb_c = (dataa == datab);
        agb_c = ($signed(dataa) > $signed(datab));
    end

    // Output registers: reset dominates, clk_en gates every update.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            result   <= '0;
            overflow <= 1'b0;
            aeb      <= 1'b0;
            agb      <= 1'b0;
        end else if (clk_en) begin
            result   <= res_c;
            overflow <= ovf_c;
            aeb      <= aeb_c;
            agb      <= agb_c;
        end
    end

endmodule

// File: tb/tb_fixed_addsub_cmp.sv
// Self-checking bench for fixed_addsub_cmp at default parameters, using an
// integer-arithmetic reference model. Honors FIXED_ADDSUB_SATURATE_EN.
module tb_fixed_addsub_cmp;

    localparam int unsigned DW = 22;
    localparam longint MAX_V = (longint'(1) <<< (DW - 1)) - 1;
    localparam longint MIN_V = -(longint'(1) <<< (DW - 1));

    logic          clk;
    logic          reset_n;
    logic          clk_en;
    logic          add_sub;
    logic [DW-1:0] dataa;
    logic [DW-1:0] datab;
    logic [DW-1:0] result;
    logic          overflow;
    logic          aeb;
    logic          agb;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] exp_res = '0;
    logic          exp_ovf = 1'b0;
    logic          exp_aeb = 1'b0;
    logic          exp_agb = 1'b0;

    fixed_addsub_cmp dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .clk_en   (clk_en),
        .add_sub  (add_sub),
        .dataa    (dataa),
        .datab    (datab),
        .result   (result),
        .overflow (overflow),
        .aeb      (aeb),
        .agb      (agb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: operate on the real signed values, then range-check.
    task automatic model(input logic as, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         output logic [DW-1:0] r, output logic ov, output logic eq, output logic gt);
        longint sa;
        longint sb;
        longint t;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        t  = as ? (sa + sb) : (sa - sb);
        ov = (t > MAX_V) || (t < MIN_V);
`ifdef FIXED_ADDSUB_SATURATE_EN
        if (t > MAX_V)      r = DW'(MAX_V);
        else if (t < MIN_V) r = DW'(MIN_V);
        else                r = DW'(t);
`else
        r = DW'(t);
`endif
        eq = (sa == sb);
        gt = (sa > sb);
    endtask

    task automatic check_outs(input string tag);
        check({tag, ".result"},   64'(result),   64'(exp_res));
        check({tag, ".overflow"}, 64'(overflow), 64'(exp_ovf));
        check({tag, ".aeb"},      64'(aeb),      64'(exp_aeb));
        check({tag, ".agb"},      64'(agb),      64'(exp_agb));
    endtask

    task automatic clear_exp();
        exp_res = '0;
        exp_ovf = 1'b0;
        exp_aeb = 1'b0;
        exp_agb = 1'b0;
    endtask

    // Drive operands, cross one rising edge, sample 1 time unit after it.
    task automatic apply(input string tag, input logic ce, input logic as,
                         input logic [DW-1:0] a, input logic [DW-1:0] b);
        clk_en  = ce;
        add_sub = as;
        dataa   = a;
        datab   = b;
        if (ce) model(as, a, b, exp_res, exp_ovf, exp_aeb, exp_agb);
        @(posedge clk);
        #1;
        check_outs(tag);
    endtask

    function automatic logic [DW-1:0] rand_op();
        case ($urandom_range(0, 6))
            0:       return '0;
            1:       return DW'(MIN_V);
            2:       return DW'(MAX_V);
            3:       return '1;
            4:       return DW'(1);
            default: return DW'($urandom());
        endcase
    endfunction

    initial begin
        reset_n = 1'b1;
        clk_en  = 1'b0;
        add_sub = 1'b0;
        dataa   = '0;
        datab   = '0;

        // Reset acts without a clock edge and overrides clk_en.
        #1;
        reset_n = 1'b0;
        clk_en  = 1'b1;
        add_sub = 1'b1;
        dataa   = 22'h0ABCDE;
        datab   = 22'h012345;
        #1;
        clear_exp();
        check_outs("reset_async");
        repeat (2) @(posedge clk);
        #1;
        check_outs("reset_dominates_en");
        reset_n = 1'b1;

        // Directed vectors.
        apply("add_1p0_0p5", 1'b1, 1'b1, 22'h100000, 22'h080000);
        check("add_1p0_0p5.const", 64'(result), 64'h180000);
        apply("sub_0p5_1p0", 1'b1, 1'b0, 22'h080000, 22'h100000);
        check("sub_0p5_1p0.const", 64'(result), 64'h380000);
        apply("ovf_add_max", 1'b1, 1'b1, 22'h1FFFFF, 22'h000001);
        check("ovf_add_max.ovf_const", 64'(overflow), 64'h1);
`ifdef FIXED_ADDSUB_SATURATE_EN
        check("ovf_add_max.const", 64'(result), 64'h1FFFFF);
`else
        check("ovf_add_max.const", 64'(result), 64'h200000);
`endif
        apply("eq_neg", 1'b1, 1'b0, 22'h3C0000, 22'h3C0000);
        check("eq_neg.aeb_const", 64'(aeb), 64'h1);
        apply("zero_gt_m1", 1'b1, 1'b1, 22'h000000, 22'h3FFFFF);
        check("zero_gt_m1.agb_const", 64'(agb), 64'h1);
        apply("sub_zero_min", 1'b1, 1'b0, 22'h000000, 22'h200000);
        check("sub_zero_min.ovf_const", 64'(overflow), 64'h1);
        apply("min_vs_m1", 1'b1, 1'b1, 22'h200000, 22'h3FFFFF);
        apply("add_min_min", 1'b1, 1'b1, 22'h200000, 22'h200000);

        // Hold with clk_en low while operands change.
        apply("load", 1'b1, 1'b1, 22'h012345, 22'h054321);
        for (int i = 0; i < 3; i++) begin
            apply($sformatf("hold%0d", i), 1'b0, $urandom_range(0, 1) != 0, rand_op(), rand_op());
        end

        // Reset in the middle of a cycle discards the in-flight operation.
        clk_en  = 1'b1;
        add_sub = 1'b1;
        dataa   = 22'h0FFFFF;
        datab   = 22'h000123;
        #3;
        reset_n = 1'b0;
        #1;
        clear_exp();
        check_outs("mid_reset_async");
        @(posedge clk);
        #1;
        check_outs("mid_reset_edge");
        reset_n = 1'b1;
        apply("post_reset_idle", 1'b0, 1'b1, 22'h0FFFFF, 22'h000123);
        apply("post_reset_load", 1'b1, 1'b0, 22'h0FFFFF, 22'h000123);

        // Randomized traffic with corner-biased operands and sporadic enable.
        for (int i = 0; i < 400; i++) begin
            apply($sformatf("rnd%0d", i), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 1) != 0, rand_op(), rand_op());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fixed_addsub_cmp.md
FIXED_ADDSUB_CMP -- requirements
Module: fixed_addsub_cmp

Interface
REQ-001 The block SHALL have parameter INTEGER_WIDTH, default 2, integer bits including sign, two's-complement.
REQ-002 The block SHALL have parameter DECIMAL_WIDTH, default 20, fractional bits.
REQ-003 The block SHALL have parameter DATA_WIDTH, default INTEGER_WIDTH+DECIMAL_WIDTH (22), operand and result width.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-005 Port clk  input  1  rising-edge clock.
REQ-006 Port reset_n  input  1  asynchronous active-low reset.
REQ-007 Port clk_en  input  1  register update enable.
REQ-008 Port add_sub  input  1  1 = add (dataa+datab), 0 = subtract (dataa-datab).
REQ-009 Port dataa  input  DATA_WIDTH  signed fixed-point operand A.
REQ-010 Port datab  input  DATA_WIDTH  signed fixed-point operand B.
REQ-011 Port result  output  DATA_WIDTH  registered signed sum/difference.
REQ-012 Port overflow  output  1  registered flag: true result outside representable range.
REQ-013 Port aeb  output  1  registered flag: dataa == datab.
REQ-014 Port agb  output  1  registered flag: dataa > datab, signed.

Function
REQ-015 All outputs SHALL be registered; latency exactly 1 clk edge with clk_en=1 from operand sample to output.
REQ-016 On a rising clk edge with clk_en=1, result, overflow, aeb, agb SHALL load values computed from dataa, datab, add_sub present before that edge.
REQ-017 With clk_en=0 all outputs SHALL hold their value.
REQ-018 Arithmetic SHALL be two's-complement at full precision internally (DATA_WIDTH+1 bits); no rounding, binary point unchanged.
REQ-019 overflow SHALL be 1 when the DATA_WIDTH+1-bit true result cannot be represented in DATA_WIDTH bits (add: same-sign operands, result sign differs; sub: opposite-sign operands, result sign differs from dataa).
REQ-020 Without saturation, result SHALL be the low DATA_WIDTH bits of the true result (wrap-around).
REQ-021 Comparison SHALL treat both operands as signed; exactly one of aeb, agb, or neither (dataa<datab) is asserted; aeb and agb never both 1.
REQ-022 Comparison SHALL be independent of add_sub.
REQ-023 Most-negative operand (e.g. 0x200000) SHALL be handled: subtracting it from 0 overflows; comparing it yields agb=0 against any other value.

Reset
REQ-024 reset_n=0 SHALL immediately, without clk, force result=0, overflow=0, aeb=0, agb=0.
REQ-025 Reset SHALL dominate clk_en; the first update after deassertion occurs on the first rising clk edge with reset_n=1 and clk_en=1.
REQ-026 Reset asserted mid-operation SHALL discard the in-flight value; no stale result appears after release.

Configuration
REQ-027 Macro FIXED_ADDSUB_SATURATE_EN, when defined, SHALL clamp result on overflow to max positive (0x1FFFFF at defaults) for positive true results or min negative (0x200000) for negative; overflow flag still asserted.
REQ-028 Without FIXED_ADDSUB_SATURATE_EN, result SHALL wrap per REQ-020; all other behaviour identical.

Verification
REQ-029 Add: dataa=0x100000 (1.0), datab=0x080000 (0.5), add_sub=1, clk_en=1 -> next edge result=0x180000, overflow=0, aeb=0, agb=1.
REQ-030 Sub: dataa=0x080000, datab=0x100000, add_sub=0 -> result=0x380000 (-0.5), overflow=0, agb=0, aeb=0.
REQ-031 Overflow: dataa=0x1FFFFF, datab=0x000001, add_sub=1 -> overflow=1; result=0x200000 without macro, 0x1FFFFF with FIXED_ADDSUB_SATURATE_EN.
REQ-032 Equality/sign compare: dataa=datab=0x3C0000 -> aeb=1, agb=0; dataa=0x000000, datab=0x3FFFFF (-1 LSB) -> agb=1.
REQ-033 Enable/reset: load a value, then clk_en=0 with new operands for 3 edges -> outputs unchanged; pulse reset_n=0 between edges -> all outputs 0 immediately, first clk_en=1 edge after release loads fresh result.
